// File: rtl/pool_stream_out.sv
// pool_stream_out
// Readout stage for the max-pooling block. One pass per start pulse. Each pass
// reads NUM_WORDS pooled words from the output BRAM in ascending address order
// and streams them out on a valid/ready interface. A small FIFO absorbs the
// one-cycle BRAM read latency and any sink backpressure.
//
// Optional build macro: POOL_OUT_CLAMP_EN. When it is defined, m_data is
// clamped to CLAMP_MAX. When it is undefined, the FIFO head passes through
// unmodified.
//
// Ports:
//   clk      in   single clock; all logic runs on the rising edge
//   rst      in   synchronous active-high reset
//   start    in   begin a pass; only sampled in IDLE, and ignored in the done cycle
//   busy     out  high while a pass is in progress
//   done     out  one-cycle pulse when the last beat has been accepted
//   rd_addr  out  BRAM read address
//   rd_en    out  BRAM read strobe
//   rd_data  in   BRAM read data, valid one cycle after rd_en
//   m_valid  out  stream beat valid (FIFO not empty)
//   m_ready  in   sink accepts the current beat
//   m_data   out  stream payload
//   m_last   out  marks beat NUM_WORDS-1
//
// States:
//   IDLE  | waiting for start
//   READ  | issuing BRAM reads while FIFO credits are available
//   DRAIN | all reads issued; emptying the FIFO until the last beat is accepted

module pool_stream_out #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8,
    parameter int NUM_WORDS  = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int CLAMP_MAX  = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int BW = $clog2(NUM_WORDS + 1);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_WORDS - 1);
    localparam logic [BW-1:0]         LAST_BEAT = BW'(NUM_WORDS - 1);
    localparam logic [CW:0]           DEPTH_EXT = (CW + 1)'(FIFO_DEPTH);
    localparam logic [DATA_WIDTH-1:0] CLAMP_VAL = DATA_WIDTH'(CLAMP_MAX);

`ifdef POOL_OUT_CLAMP_EN
    localparam bit CLAMP_ON = 1'b1;
`else
    localparam bit CLAMP_ON = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_DRAIN
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [ADDR_WIDTH-1:0] rd_cnt;
    logic [BW-1:0]         beat_cnt;
    logic                  inflight;

    logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         fifo_count;

    logic                  push;
    logic                  pop;
    logic                  start_ok;
    logic                  last_pop;
    logic                  credit_ok;
    logic [DATA_WIDTH-1:0] head;

    // A read is issued only if both the buffered words and the word still in
    // flight fit in the FIFO. Because of this, the unconditional push can never
    // overflow the FIFO.
    assign credit_ok = ({1'b0, fifo_count} + (CW + 1)'(inflight)) < DEPTH_EXT;

    assign push     = inflight;
    assign m_valid  = (fifo_count != '0);
    assign pop      = m_valid && m_ready;
    assign last_pop = pop && (beat_cnt == LAST_BEAT);

    assign busy     = (state != S_IDLE);
    assign rd_addr  = rd_cnt;
    assign m_last   = m_valid && (beat_cnt == LAST_BEAT);

    assign head     = fifo_mem[rd_ptr];
    // Forcing m_data to zero while the FIFO is empty gives a defined reset value
    // without having to reset the storage array.
    assign m_data   = !m_valid ? '0
                    : ((CLAMP_ON && (head > CLAMP_VAL)) ? CLAMP_VAL : head);

    always_comb begin
        state_nxt = state;
        rd_en     = 1'b0;
        start_ok  = 1'b0;
        case (state)
            S_IDLE: begin
                // done is high only in the cycle right after the pass ends,
                // so gating on it drops a start that arrives in that cycle.
                if (start && !done) begin
                    start_ok  = 1'b1;
                    state_nxt = S_READ;
                end
            end
            S_READ: begin
                if (credit_ok) begin
                    rd_en = 1'b1;
                    if (rd_cnt == LAST_ADDR) begin
                        state_nxt = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (last_pop) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            rd_cnt     <= '0;
            beat_cnt   <= '0;
            inflight   <= 1'b0;
            done       <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            state    <= state_nxt;
            inflight <= rd_en;
            done     <= last_pop;

            if (start_ok) begin
                rd_cnt   <= '0;
                beat_cnt <= '0;
            end else begin
                // The counter stops at the last address, so rd_addr holds
                // that address through DRAIN.
                if (rd_en && (rd_cnt != LAST_ADDR)) begin
                    rd_cnt <= rd_cnt + ADDR_WIDTH'(1);
                end
                if (pop) begin
                    beat_cnt <= beat_cnt + BW'(1);
                end
            end

            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= rd_data;
        end
    end

endmodule
